// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared types and constants for the instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

  localparam int OP_W     = 4;
  localparam int ONEHOT_W = 12;
  localparam int INSTR_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Opcodes 1..12 are legal; 12 doubles as the halt instruction.
  localparam logic [OP_W-1:0] OPC_FIRST = 4'd1;
  localparam logic [OP_W-1:0] OPC_LAST  = 4'd12;
  localparam logic [OP_W-1:0] OPC_HALT  = 4'd12;

  function automatic logic opcode_is_legal(input logic [OP_W-1:0] op);
    return (op >= OPC_FIRST) && (op <= OPC_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_onehot.sv
`default_nettype none
// ============================================================================
// Module      : opcode_onehot
// Description : Combinational 4-to-12 opcode one-hot map with legality flag.
// Revision    : 1.0 - initial release
// ============================================================================
module opcode_onehot
  import instr_sequencer_pkg::*;
(
  input  logic [OP_W-1:0]     i_opcode,
  output logic [ONEHOT_W-1:0] o_onehot,
  output logic                o_legal
);

  always_comb begin
    o_legal  = opcode_is_legal(i_opcode);
    o_onehot = '0;
    if (o_legal) begin
      o_onehot = ONEHOT_W'(1) << (i_opcode - OPC_FIRST);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/execute control sequencer owning the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int                  PC_W       = 8,
  parameter logic [ONEHOT_W-1:0] MULTI_MASK = 12'b000010000000,
  parameter logic [OP_W-1:0]     HALT_OP    = OPC_HALT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                instr_req,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  output logic [PC_W-1:0]     pc,
  output logic                en_op,
  output logic                en_out,
  output logic [ONEHOT_W-1:0] op_onehot,
  output logic [ONEHOT_W-1:0] operand,
  output logic                exec_en,
  input  logic                exec_done,
  output logic                illegal,
  output logic                busy,
  output logic                halted
);

  state_t                r_state;
  logic [INSTR_W-1:0]    r_ir;
  logic [PC_W-1:0]       r_pc;
  logic [ONEHOT_W-1:0]   r_op_onehot;
  logic [ONEHOT_W-1:0]   r_operand;
  logic                  r_instr_req;
  logic                  r_en_op;
  logic                  r_en_out;
  logic                  r_exec_en;
  logic                  r_illegal;
  logic                  r_busy;
  logic                  r_halted;

  logic [ONEHOT_W-1:0]   w_dec_onehot;
  logic                  w_dec_legal;
  logic [OP_W-1:0]       w_opcode;

  assign w_opcode = r_ir[INSTR_W-1 -: OP_W];

  opcode_onehot u_decode (
    .i_opcode (w_opcode),
    .o_onehot (w_dec_onehot),
    .o_legal  (w_dec_legal)
  );

  // Outputs are registered against the next state, so each is a clean Moore
  // view of the state actually entered on this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_pc        <= '0;
      r_op_onehot <= '0;
      r_operand   <= '0;
      r_instr_req <= 1'b0;
      r_en_op     <= 1'b0;
      r_en_out    <= 1'b0;
      r_exec_en   <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_en_op   <= 1'b0;
      r_en_out  <= 1'b0;
      r_exec_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_FETCH;
            r_instr_req <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            r_ir        <= instr;
            r_pc        <= r_pc + PC_W'(1);
            r_state     <= S_DECODE;
            r_instr_req <= 1'b0;
            r_en_op     <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_dec_legal) begin
            r_op_onehot <= w_dec_onehot;
            r_operand   <= r_ir[ONEHOT_W-1:0];
            r_state     <= S_EXEC;
            r_en_out    <= 1'b1;
            r_exec_en   <= 1'b1;
          end else begin
            r_illegal   <= 1'b1;
            r_op_onehot <= '0;
            r_state     <= S_FETCH;
            r_instr_req <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_opcode == HALT_OP) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (|(MULTI_MASK & r_op_onehot)) begin
            r_state <= S_WAIT;
          end else begin
            r_state     <= S_FETCH;
            r_instr_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (exec_done) begin
            r_state     <= S_FETCH;
            r_instr_req <= 1'b1;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state     <= S_IDLE;
          r_instr_req <= 1'b0;
          r_busy      <= 1'b0;
          r_halted    <= 1'b0;
        end
      endcase
    end
  end

  assign instr_req = r_instr_req;
  assign pc        = r_pc;
  assign en_op     = r_en_op;
  assign en_out    = r_en_out;
  assign exec_en   = r_exec_en;
  assign op_onehot = r_op_onehot;
  assign operand   = r_operand;
  assign illegal   = r_illegal;
  assign busy      = r_busy;
  assign halted    = r_halted;

endmodule
`default_nettype wire
